turbosim_iter_ctrl: RTL and testbench

TURBOSIM_ITER_CTRL -- requirements
Module: turbosim_iter_ctrl

---
 rtl/turbosim_iter_ctrl.sv | 94 +++++++++
 tb/tb_turbosim_iter_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/turbosim_iter_ctrl.sv
// turbosim_iter_ctrl: sequences one turbosim iteration (load stimulus, go, wait/drain changes, finish).
// Optional WAIT watchdog is compiled in with TS_ITER_CTRL_TIMEOUT_EN.
module turbosim_iter_ctrl #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        stim_valid,
    input  logic [31:0] stim_record,
    input  logic        stim_last,
    output logic        stim_ready,
    output logic        ts_wr,
    output logic [31:0] ts_in_record,
    input  logic        ts_full,
    output logic        ts_go,
    input  logic        ts_done,
    output logic        ts_rd,
    input  logic        ts_empty,
    input  logic [31:0] ts_out_record,
    output logic        chg_valid,
    output logic [31:0] chg_record,
    output logic        busy,
    output logic        iter_done,
    output logic [15:0] cycle_count,
    output logic [15:0] change_count,
    output logic        timeout_err
);
    typedef enum logic [2:0] {IDLE, LOAD, GO, WAIT, FIN} state_t;
    state_t state, state_nxt;
    logic done_low, done_ok, timeout_hit, begin_iter;
    logic [15:0] cyc_inc;
    assign cyc_inc = (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
    // completion waits for an empty output FIFO so a late record is drained first
    assign done_ok = done_low && ts_done && ts_empty;
    assign begin_iter = (state == IDLE) && start;
`ifdef TS_ITER_CTRL_TIMEOUT_EN
    assign timeout_hit = (state == WAIT) && (cyc_inc >= TIMEOUT_CYCLES);
    always_ff @(posedge clk) begin
        if (rst || begin_iter)
            timeout_err <= 1'b0;
        else if (timeout_hit)
            timeout_err <= 1'b1;
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif
    always_comb begin
        state_nxt    = state;
        stim_ready   = (state == LOAD) && !ts_full;
        ts_wr        = stim_valid && stim_ready;
        ts_in_record = stim_record;
        ts_go        = (state == GO);
        ts_rd        = (state != IDLE) && !ts_empty;
        busy         = (state != IDLE);
        iter_done    = (state == FIN);
        case (state)
            IDLE:    state_nxt = start ? LOAD : IDLE;
            LOAD:    state_nxt = (ts_wr && stim_last) ? GO : LOAD;
            GO:      state_nxt = WAIT;
            WAIT:    state_nxt = (done_ok || timeout_hit) ? FIN : WAIT;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            done_low     <= 1'b0;
            chg_valid    <= 1'b0;
            chg_record   <= '0;
            cycle_count  <= '0;
            change_count <= '0;
        end else begin
            state     <= state_nxt;
            chg_valid <= ts_rd;
            if (ts_rd)
                chg_record <= ts_out_record;
            if (begin_iter) begin
                cycle_count  <= '0;
                change_count <= '0;
                done_low     <= 1'b0;
            end else begin
                if (ts_rd && change_count != 16'hFFFF)
                    change_count <= change_count + 16'd1;
                if (state == WAIT)
                    cycle_count <= cyc_inc;
                if (state == WAIT && !ts_done)
                    done_low <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_turbosim_iter_ctrl.sv
// tb_turbosim_iter_ctrl: directed vector table plus hand sequences for turbosim_iter_ctrl.
module tb_turbosim_iter_ctrl;
`ifdef TS_ITER_CTRL_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd100;
`else
    localparam logic [15:0] TO = 16'd50000;
`endif
    logic clk = 0, rst = 1, start = 0, stim_valid = 0, stim_last = 0;
    logic ts_full = 0, ts_done = 1, ts_empty = 1;
    logic [31:0] stim_record = '0, ts_out_record = '0;
    logic stim_ready, ts_wr, ts_go, ts_rd, chg_valid, busy, iter_done, timeout_err;
    logic [31:0] ts_in_record, chg_record;
    logic [15:0] cycle_count, change_count;
    int tests = 0, fails = 0;

    typedef struct packed {
        logic [6:0]  in;
        logic [31:0] rec;
        logic [6:0]  exp;
    } vec_t;
    vec_t tv[18];
    logic [31:0] d[4];

    turbosim_iter_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .stim_valid(stim_valid),
        .stim_record(stim_record), .stim_last(stim_last), .stim_ready(stim_ready),
        .ts_wr(ts_wr), .ts_in_record(ts_in_record), .ts_full(ts_full), .ts_go(ts_go),
        .ts_done(ts_done), .ts_rd(ts_rd), .ts_empty(ts_empty), .ts_out_record(ts_out_record),
        .chg_valid(chg_valid), .chg_record(chg_record), .busy(busy), .iter_done(iter_done),
        .cycle_count(cycle_count), .change_count(change_count), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic begin_iter(input logic [31:0] r);
        start = 1;
        cyc();
        start = 0;
        stim_valid = 1;
        stim_last = 1;
        stim_record = r;
        #1;
        chk("load_wr", {31'd0, ts_wr}, 1);
        cyc();
        stim_valid = 0;
        stim_last = 0;
        #1;
        chk("go_pulse", {31'd0, ts_go}, 1);
    endtask

    initial begin
        int ncv, nid, tid, bad;
        // in = {rst,start,vld,last,full,done,empty}; exp = {rdy,wr,go,rd,busy,idn,cv}
        tv[0]  = '{7'b1000011, 32'h0,        7'b0000000};
        tv[1]  = '{7'b0110011, 32'hA000_0001, 7'b0000000};
        tv[2]  = '{7'b0010011, 32'hA000_0001, 7'b1100100};
        for (int i = 3; i <= 7; i++) tv[i] = '{7'b0010111, 32'hB000_0002, 7'b0000100};
        tv[8]  = '{7'b0010011, 32'hB000_0002, 7'b1100100};
        tv[9]  = '{7'b0000011, 32'hC000_0003, 7'b1000100};
        tv[10] = '{7'b0011011, 32'hC000_0003, 7'b1100100};
        tv[11] = '{7'b0110011, 32'hD000_0004, 7'b0010100};
        tv[12] = '{7'b0000011, 32'h0,        7'b0000100};
        tv[13] = '{7'b0000001, 32'h0,        7'b0000100};
        tv[14] = '{7'b0000010, 32'h5A5A_0011, 7'b0001100};
        tv[15] = '{7'b0000011, 32'h0,        7'b0000101};
        tv[16] = '{7'b0100011, 32'h0,        7'b0000110};
        tv[17] = '{7'b0000011, 32'h0,        7'b0000000};
        d = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004};

        cyc();
        cyc();
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, stim_ready}, 0);
        chk("rst_cnts", {cycle_count, change_count}, 0);
        chk("rst_chg", chg_record, 0);
        chk("rst_flags", {28'd0, ts_go, iter_done, chg_valid, timeout_err}, 0);

        for (int i = 0; i < 18; i++) begin
            {rst, start, stim_valid, stim_last, ts_full, ts_done, ts_empty} = tv[i].in;
            stim_record = tv[i].rec;
            ts_out_record = tv[i].rec;
            #1;
            chk($sformatf("vec%0d_flags", i),
                {25'd0, stim_ready, ts_wr, ts_go, ts_rd, busy, iter_done, chg_valid}, {25'd0, tv[i].exp});
            chk($sformatf("vec%0d_rec", i), ts_in_record, tv[i].rec);
            cyc();
        end
        chk("tbl_cycle_count", {16'd0, cycle_count}, 4);
        chk("tbl_change_count", {16'd0, change_count}, 1);
        chk("tbl_chg_record", chg_record, 32'h5A5A_0011);

        // done drops after go, four drained records, done rises at t=21
        begin_iter(32'h0000_0001);
        ncv = 0; nid = 0; tid = 0; bad = 0;
        for (int t = 1; t <= 25; t++) begin
            cyc();
            ts_done = (t == 1) || (t >= 21);
            ts_empty = !(t >= 5 && t <= 8);
            ts_out_record = (t >= 5 && t <= 8) ? d[t-5] : 32'hDEAD_BEEF;
            #1;
            if (chg_valid) begin
                if (ncv < 4 && chg_record !== d[ncv]) bad++;
                ncv++;
            end
            if (iter_done) begin
                nid++;
                tid = t;
            end
        end
        ts_empty = 1;
        chk("drain_chg_pulses", ncv, 4);
        chk("drain_chg_data_bad", bad, 0);
        chk("drain_iter_done_cnt", nid, 1);
        chk("drain_iter_done_t", tid, 22);
        chk("drain_cycle_count", {16'd0, cycle_count}, 21);
        chk("drain_change_count", {16'd0, change_count}, 4);

        // done held high: no exit until it falls then rises
        begin_iter(32'h0000_0002);
        nid = 0;
        repeat (30) begin
            cyc();
            if (iter_done) nid++;
        end
        chk("hold_no_done", nid, 0);
        chk("hold_busy", {31'd0, busy}, 1);
        ts_done = 0;
        cyc();
        ts_done = 1;
        cyc();
        chk("hold_iter_done", {31'd0, iter_done}, 1);
        cyc();
        chk("hold_idle", {31'd0, busy}, 0);

        // reset in WAIT, then a normal iteration
        begin_iter(32'h0000_0003);
        cyc();
        ts_done = 0;
        ts_empty = 0;
        ts_out_record = 32'h7777_0005;
        cyc();
        cyc();
        rst = 1;
        cyc();
        chk("wrst_busy", {31'd0, busy}, 0);
        chk("wrst_flags", {26'd0, ts_rd, chg_valid, stim_ready, ts_go, iter_done, timeout_err}, 0);
        chk("wrst_cnts", {cycle_count, change_count}, 0);
        chk("wrst_chg", chg_record, 0);
        rst = 0;
        ts_empty = 1;
        ts_done = 1;
        cyc();
        begin_iter(32'h0000_0004);
        cyc();
        ts_done = 0;
        cyc();
        ts_done = 1;
        cyc();
        chk("post_rst_iter_done", {31'd0, iter_done}, 1);
        chk("post_rst_cycle_count", {16'd0, cycle_count}, 2);
        cyc();

`ifdef TS_ITER_CTRL_TIMEOUT_EN
        begin_iter(32'h0000_0005);
        ts_done = 0;
        tid = 0;
        for (int t = 1; t <= 110; t++) begin
            cyc();
            if (iter_done && tid == 0) tid = t;
        end
        chk("to_iter_done_t", tid, 101);
        chk("to_err", {31'd0, timeout_err}, 1);
        chk("to_cycle_count", {16'd0, cycle_count}, 100);
        ts_done = 1;
        start = 1;
        cyc();
        start = 0;
        #1;
        chk("to_err_cleared", {31'd0, timeout_err}, 0);
`else
        begin_iter(32'h0000_0005);
        ts_done = 0;
        repeat (120) cyc();
        chk("noto_err", {31'd0, timeout_err}, 0);
        chk("noto_busy", {31'd0, busy}, 1);
`endif
        rst = 1;
        cyc();
        rst = 0;
        ts_done = 1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
